// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and 3-cycle access sequencer for the data memory.
// Optional build macro DMEM_ARB_MISALIGN_CHECK_EN enables the alignment error check.
module dmem_arbiter #(
    parameter int   DEPTH   = 32,
    parameter logic RR_INIT = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req_i,
    input  logic [1:0]  we_i,
    input  logic [31:0] addr0_i,
    input  logic [31:0] addr1_i,
    input  logic [31:0] wdata0_i,
    input  logic [31:0] wdata1_i,
    input  logic [2:0]  size0_i,
    input  logic [2:0]  size1_i,
    output logic [1:0]  gnt_o,
    output logic [1:0]  rvalid_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        mem_wr,
    output logic [31:0] addr_mem,
    output logic [31:0] wdata_mem,
    output logic [2:0]  rd_wr_mem,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
    } mreq_t;

    // Illegal codes collapse to byte access so the memory never sees them.
    function automatic logic [2:0] norm_size(input logic [2:0] s);
        case (s)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: norm_size = s;
            default:                                norm_size = 3'b000;
        endcase
    endfunction

    state_t      state, state_nxt;
    mreq_t       req_q, req_sel;
    logic        ptr, owner, win;
    logic [2:0]  nbytes;
    logic [32:0] end_addr;
    logic        range_err, mis_err, acc_err;

    always_comb begin
        win     = (req_i == 2'b11) ? ~ptr : req_i[1];
        req_sel = win ? '{we_i[1], addr1_i, wdata1_i, norm_size(size1_i)}
                      : '{we_i[0], addr0_i, wdata0_i, norm_size(size0_i)};
    end

    always_comb begin
        case (req_q.size[1:0])
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        // 33-bit sum so addresses near 2^32 cannot wrap into range.
        end_addr  = {1'b0, req_q.addr} + {30'd0, nbytes};
        range_err = end_addr > 33'(DEPTH);
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
        mis_err = ((req_q.size[1:0] == 2'b01) && req_q.addr[0]) ||
                  ((req_q.size == 3'b010) && (req_q.addr[1:0] != 2'b00));
`else
        mis_err = 1'b0;
`endif
        acc_err = range_err | mis_err;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req_i) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory port is only driven during ACCESS; reset clears state so mem_wr drops at once.
    always_comb begin
        mem_wr    = 1'b0;
        addr_mem  = 32'd0;
        wdata_mem = 32'd0;
        rd_wr_mem = 3'b010;
        if (state == ACCESS) begin
            mem_wr    = req_q.we & ~acc_err;
            addr_mem  = req_q.addr;
            wdata_mem = req_q.wdata;
            rd_wr_mem = req_q.size;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= RR_INIT;
            owner    <= 1'b0;
            req_q    <= '0;
            gnt_o    <= 2'b00;
            rvalid_o <= 2'b00;
            err_o    <= 1'b0;
            rdata_o  <= 32'd0;
        end else begin
            state    <= state_nxt;
            gnt_o    <= 2'b00;
            rvalid_o <= 2'b00;
            case (state)
                IDLE: if (|req_i) begin
                    req_q <= req_sel;
                    owner <= win;
                    ptr   <= win;
                    gnt_o <= win ? 2'b10 : 2'b01;
                end
                ACCESS: begin
                    err_o    <= acc_err;
                    rdata_o  <= (!req_q.we && !acc_err) ? mem_rdata : 32'd0;
                    rvalid_o <= owner ? 2'b10 : 2'b01;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, contention/reset sequences,
// and randomized accesses checked against a byte-array reference model.
module tb_dmem_arbiter;

    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req_i = '0, we_i = '0;
    logic [31:0] addr0_i = '0, addr1_i = '0, wdata0_i = '0, wdata1_i = '0;
    logic [2:0]  size0_i = 3'b010, size1_i = 3'b010;
    logic [1:0]  gnt_o, rvalid_o;
    logic        err_o, mem_wr;
    logic [31:0] rdata_o, addr_mem, wdata_mem, mem_rdata;
    logic [2:0]  rd_wr_mem;

    int n_pass = 0, n_total = 0;

    dmem_arbiter #(.DEPTH(DEPTH), .RR_INIT(1'b1)) dut (
        .clock(clock), .reset(reset), .req_i(req_i), .we_i(we_i),
        .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
        .size0_i(size0_i), .size1_i(size1_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .err_o(err_o), .rdata_o(rdata_o), .mem_wr(mem_wr), .addr_mem(addr_mem),
        .wdata_mem(wdata_mem), .rd_wr_mem(rd_wr_mem), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Data memory: combinational read with extension, write on falling edge.
    logic [7:0]  mem     [DEPTH] = '{default: 8'h00};
    logic [7:0]  ref_mem [DEPTH] = '{default: 8'h00};
    logic [31:0] raw;

    always_comb begin
        raw = '0;
        for (int k = 0; k < 4; k++)
            if (int'(addr_mem) + k < DEPTH) raw[8*k +: 8] = mem[AW'(int'(addr_mem) + k)];
        case (rd_wr_mem)
            3'b000:  mem_rdata = {{24{raw[7]}}, raw[7:0]};
            3'b001:  mem_rdata = {{16{raw[15]}}, raw[15:0]};
            3'b100:  mem_rdata = {24'h0, raw[7:0]};
            3'b101:  mem_rdata = {16'h0, raw[15:0]};
            default: mem_rdata = raw;
        endcase
    end

    always @(negedge clock) begin
        if (mem_wr)
            for (int k = 0; k < 4; k++)
                if ((k < (rd_wr_mem[1:0] == 2'b00 ? 1 : rd_wr_mem[1:0] == 2'b01 ? 2 : 4)) &&
                    (int'(addr_mem) + k < DEPTH))
                    mem[AW'(int'(addr_mem) + k)] <= wdata_mem[8*k +: 8];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [2:0] legal_size(input logic [2:0] s);
        return (s == 3'b011 || s[2:1] == 2'b11) ? 3'b000 : s;
    endfunction

    // Reference: what the access should do to a byte array, from the access rules.
    task automatic ref_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] size, output logic err, output logic [31:0] rd);
        logic [2:0]  s;
        int          n;
        logic [31:0] v;
        s   = legal_size(size);
        n   = (s[1:0] == 2'b00) ? 1 : (s[1:0] == 2'b01) ? 2 : 4;
        err = ({1'b0, addr} + 33'(n)) > 33'(DEPTH);
        if (MIS && ((n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00))) err = 1'b1;
        rd = 32'd0;
        v  = 32'd0;
        if (!err) begin
            for (int k = 0; k < n; k++) begin
                if (we) ref_mem[AW'(int'(addr) + k)] = wdata[8*k +: 8];
                else    v[8*k +: 8] = ref_mem[AW'(int'(addr) + k)];
            end
            if (!we) begin
                if (s == 3'b000)      rd = {{24{v[7]}}, v[7:0]};
                else if (s == 3'b001) rd = {{16{v[15]}}, v[15:0]};
                else                  rd = v;
            end
        end
    endtask

    // One access through an idle arbiter, checking every phase of the 3-cycle sequence.
    task automatic xact(input int port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] size,
                        input logic exp_err, input logic [31:0] exp_rd, input string tag);
        int waited;
        @(negedge clock);
        if (port == 0) begin we_i[0] = we; addr0_i = addr; wdata0_i = wdata; size0_i = size; end
        else           begin we_i[1] = we; addr1_i = addr; wdata1_i = wdata; size1_i = size; end
        req_i[port] = 1'b1;
        waited = 0;
        do begin
            @(posedge clock); #1;
            waited++;
        end while (gnt_o == 2'b00 && waited < 8);
        chk({tag, " gnt"}, 32'(gnt_o), 32'(2'b01 << port));
        chk({tag, " gnt latency"}, 32'(waited), 32'd1);
        req_i = 2'b00;
        chk({tag, " mem_wr"}, 32'(mem_wr), 32'(we & ~exp_err));
        chk({tag, " addr_mem"}, addr_mem, addr);
        chk({tag, " rd_wr_mem"}, 32'(rd_wr_mem), 32'(legal_size(size)));
        @(posedge clock); #1;
        chk({tag, " rvalid"}, 32'(rvalid_o), 32'(2'b01 << port));
        chk({tag, " err"}, 32'(err_o), 32'(exp_err));
        chk({tag, " rdata"}, rdata_o, exp_rd);
        @(posedge clock); #1;
        chk({tag, " rvalid drop"}, 32'(rvalid_o), 32'd0);
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl [19];

    initial begin
        logic        e;
        logic [31:0] d;
        int          p;

        tbl[0]  = '{0, 1'b1, 32'h04, 32'hDEADBEEF, 3'b010, 1'b0, 32'h0};
        tbl[1]  = '{0, 1'b0, 32'h04, 32'h0,        3'b010, 1'b0, 32'hDEADBEEF};
        tbl[2]  = '{1, 1'b1, 32'h04, 32'h00000080, 3'b000, 1'b0, 32'h0};
        tbl[3]  = '{1, 1'b0, 32'h04, 32'h0,        3'b100, 1'b0, 32'h00000080};
        tbl[4]  = '{1, 1'b0, 32'h04, 32'h0,        3'b000, 1'b0, 32'hFFFFFF80};
        tbl[5]  = '{0, 1'b0, 32'h03, 32'h0,        3'b001, MIS,  MIS ? 32'h0 : 32'hFFFF8000};
        tbl[6]  = '{0, 1'b0, 32'h1E, 32'h0,        3'b010, 1'b1, 32'h0};
        tbl[7]  = '{0, 1'b1, 32'h20, 32'h11,       3'b000, 1'b1, 32'h0};
        tbl[8]  = '{0, 1'b1, 32'h1F, 32'h5A,       3'b000, 1'b0, 32'h0};
        tbl[9]  = '{1, 1'b0, 32'h1F, 32'h0,        3'b100, 1'b0, 32'h0000005A};
        tbl[10] = '{0, 1'b1, 32'h00, 32'h12345678, 3'b010, 1'b0, 32'h0};
        tbl[11] = '{1, 1'b0, 32'h02, 32'h0,        3'b101, 1'b0, 32'h00001234};
        tbl[12] = '{0, 1'b0, 32'h01, 32'h0,        3'b011, 1'b0, 32'h00000056};
        tbl[13] = '{0, 1'b1, 32'h1E, 32'hFFFFFFAB, 3'b111, 1'b0, 32'h0};
        tbl[14] = '{1, 1'b0, 32'h1E, 32'h0,        3'b100, 1'b0, 32'h000000AB};
        tbl[15] = '{1, 1'b0, 32'h1F, 32'h0,        3'b101, 1'b1, 32'h0};
        tbl[16] = '{0, 1'b0, 32'h1C, 32'h0,        3'b010, 1'b0, 32'h5AAB0000};
        tbl[17] = '{1, 1'b0, 32'h02, 32'h0,        3'b010, MIS,  MIS ? 32'h0 : 32'hBE801234};
        tbl[18] = '{1, 1'b0, 32'h1E, 32'h0,        3'b110, 1'b0, 32'hFFFFFFAB};

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst gnt", 32'(gnt_o), 32'd0);
        chk("rst rvalid", 32'(rvalid_o), 32'd0);
        chk("rst err", 32'(err_o), 32'd0);
        chk("rst rdata", rdata_o, 32'd0);
        chk("rst mem_wr", 32'(mem_wr), 32'd0);
        chk("rst addr_mem", addr_mem, 32'd0);
        chk("rst wdata_mem", wdata_mem, 32'd0);
        chk("rst rd_wr_mem", 32'(rd_wr_mem), 32'(3'b010));
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 19; i++) begin
            ref_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].size, e, d);
            xact(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].size,
                 tbl[i].err, tbl[i].rd, $sformatf("vec%0d", i));
        end

        // Continuous contention from reset: grants alternate every 3 cycles.
        @(negedge clock);
        reset = 1'b0;
        we_i = 2'b00; addr0_i = 0; addr1_i = 0; size0_i = 3'b010; size1_i = 3'b010;
        req_i = 2'b11;
        @(negedge clock);
        reset = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clock); #1;
            chk($sformatf("rr cycle%0d", c), 32'(gnt_o),
                (c == 1 || c == 7) ? 32'd1 : (c == 4 || c == 10) ? 32'd2 : 32'd0);
        end
        req_i = 2'b00;

        // Reset during a store's ACCESS cycle.
        @(negedge clock);
        we_i[0] = 1'b1; addr0_i = 32'h08; wdata0_i = 32'hCAFEF00D; size0_i = 3'b010;
        req_i = 2'b01;
        @(posedge clock); #1;
        chk("mid gnt", 32'(gnt_o), 32'd1);
        chk("mid mem_wr before", 32'(mem_wr), 32'd1);
        req_i = 2'b00;
        #1 reset = 1'b0;
        #1;
        chk("mid mem_wr async", 32'(mem_wr), 32'd0);
        chk("mid gnt async", 32'(gnt_o), 32'd0);
        repeat (2) begin
            @(posedge clock); #1;
            chk("mid rvalid", 32'(rvalid_o), 32'd0);
        end
        chk("mid err", 32'(err_o), 32'd0);
        chk("mid rdata", rdata_o, 32'd0);
        chk("mid addr_mem", addr_mem, 32'd0);
        chk("mid rd_wr_mem", 32'(rd_wr_mem), 32'(3'b010));
        @(negedge clock);
        reset = 1'b1;
        we_i = 2'b00; addr0_i = 32'h08; addr1_i = 32'h08; size0_i = 3'b010; size1_i = 3'b010;
        req_i = 2'b11;
        @(posedge clock); #1;
        chk("post-rst ptr gnt", 32'(gnt_o), 32'd1);
        req_i = 2'b00;
        ref_access(1'b0, 32'h08, 32'h0, 3'b010, e, d);
        @(posedge clock); #1;
        chk("post-rst rvalid", 32'(rvalid_o), 32'd1);
        chk("post-rst no write", rdata_o, d);
        @(posedge clock); #1;
        ref_access(1'b0, 32'h04, 32'h0, 3'b010, e, d);
        xact(1, 1'b0, 32'h04, 32'h0, 3'b010, e, d, "post-rst read");

        // Randomized accesses against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic        we;
            logic [31:0] a, w;
            logic [2:0]  s;
            p  = int'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            s  = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, DEPTH + 3));
            w  = $urandom;
            ref_access(we, a, w, s, e, d);
            xact(p, we, a, w, s, e, d, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the single-cycle core's byte-addressed data memory. It shares the one data-memory port between the core load/store path (port 0) and a DMA/debug requester (port 1) using a round-robin grant and a three-state access sequence. It also checks alignment and range and returns a registered response. It sits between the requesters and the data memory.

## Interface
- `DEPTH`, 32: data-memory size in bytes; valid addresses are 0..DEPTH-1.
- `RR_INIT`, 1: initial value of the last-granted pointer, so port 0 wins the first tie.
- `clock` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req_i` input 2: per-port request; held high until that port's `gnt_o` bit is seen.
- `we_i` input 2: per-port write enable (1 = store).
- `addr0_i`, `addr1_i` input 32: byte addresses.
- `wdata0_i`, `wdata1_i` input 32: store data, little-endian, low bytes used for SB/SH.
- `size0_i`, `size1_i` input 3: access code (LB_SB=000, LH_SH=001, LW_SW=010, LBU=100, LHU=101).
- `gnt_o` output 2: one-cycle registered grant pulse.
- `rvalid_o` output 2: one-cycle response pulse.
- `err_o` output 1: error flag, valid with `rvalid_o`.
- `rdata_o` output 32: registered load data, valid with `rvalid_o`; 0 for stores and errors.
- `mem_wr` output 1: memory write strobe.
- `addr_mem` output 32: memory byte address.
- `wdata_mem` output 32: memory store data.
- `rd_wr_mem` output 3: memory access code.
- `mem_rdata` input 32: combinational memory read data.

## Operation
- FSM states are IDLE, ACCESS and RESP. Each access has a fixed length of 3 cycles, with no back-to-back overlap.
- **IDLE:**
  - If any `req_i` bit is set, select the winner.
  - With a single request, that port wins.
  - With both requesting, the port not equal to the last-granted pointer wins.
  - On the edge: latch the winner's we/addr/wdata/size into the request register, set `gnt_o[winner]`, update the pointer, and go to ACCESS.
- **ACCESS:**
  - Drive `addr_mem`, `wdata_mem` and `rd_wr_mem` from the latched request.
  - `mem_wr` = latched we AND NOT error.
  - The memory commits the write on the falling edge inside this cycle.
  - On the rising edge: capture `mem_rdata` into `rdata_o` for loads with no error, otherwise capture 0. Capture the error into `err_o`. Go to RESP.
- **RESP:** assert `rvalid_o[owner]` for one cycle, then go to IDLE. Requests are not sampled in RESP.
- Error conditions, evaluated on the latched request:
  - addr + bytes(size) > DEPTH, where bytes = 1/2/4 for codes 0xx by low two bits, and 1/2 for LBU/LHU. The sum is computed in 33 bits, so there is no wrap-around.
  - Misalignment (see Configuration).
  - An illegal size code (011, 11x) is treated as LB_SB.
- Write to address 0 is forwarded unchanged. Write policy for that address is the memory's concern.
- Idle memory outputs: `mem_wr`=0, `addr_mem`=0, `wdata_mem`=0, `rd_wr_mem`=010.

## Timing
- Reset values:
  - State IDLE.
  - Pointer `RR_INIT`.
  - `gnt_o`=0, `rvalid_o`=0, `err_o`=0, `rdata_o`=0.
  - Memory outputs at their idle values.
  - Request register cleared.
- Latency: request sampled at edge N. `gnt_o` is high during cycle N+1 (ACCESS) and `rvalid_o` during N+2 (RESP). The next grant is possible at edge N+3.
- A request dropped before grant is simply not serviced. Changing `addr/size/we` while `req_i` is high but ungranted is allowed; the value at the grant edge is used.
- Port inputs are ignored after grant.
- Reset asserted mid-ACCESS: `mem_wr` drops asynchronously, no `rvalid_o` is issued, and the pointer returns to `RR_INIT`.

## Configuration
- `DMEM_ARB_MISALIGN_CHECK_EN` defined:
  - Halfword (001/101) with addr[0]=1 is an error.
  - Word (010) with addr[1:0]≠0 is an error.
  - On error there is no memory write, and the response is `err_o`=1, `rdata_o`=0.
- Not defined: misaligned accesses are forwarded to memory unchanged, and only the range check can raise `err_o`.

## Test plan
- Port 0 SW 0xDEADBEEF @0x04, then LW @0x04 → the write has `gnt_o`=01 at N+1, `mem_wr`=1 in ACCESS and `rvalid_o`=01 at N+2; the read returns `rdata_o`=0xDEADBEEF with `err_o`=0.
- Both ports request continuously from reset → grants alternate 01,10,01,10 every 3 cycles.
- LH @0x03 with macro defined → `mem_wr` never set, `rvalid_o` pulses, `err_o`=1, `rdata_o`=0. Without macro → `err_o`=0 and the access is forwarded.
- LW @0x1E (DEPTH=32), and SB @0x20 → both give `err_o`=1 with no write. SB @0x1F → `err_o`=0.
- Reset low during ACCESS of an SW → `mem_wr` falls immediately, no `rvalid_o`, outputs at reset values, and the next request is served normally.
- Port 1 LBU @0x04 after storing 0x80 → `rdata_o`=0x00000080. LB → 0xFFFFFF80.
